if_fetch_unit: RTL and testbench

Parametrised instruction-fetch stage for the MiniMIPS32 pipeline, sitting between the PC/redirect logic and the ID stage. It owns the PC register, issues pipelined requests to instruction memory over a ready/valid address channel, and buffers in-order responses in a BUF_DEPTH-entry queue. It delivers instructions to ID with a valid/ready handshake and raises AdEL for misaligned PCs. Flush and branch redirects discard all buffered and in-flight fetches.

---
 rtl/if_fetch_unit.sv | 166 ++++++++++++++++
 tb/tb_if_fetch_unit.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: MiniMIPS32 instruction-fetch stage.
// Owns the PC, issues pipelined imem requests and buffers in-order responses.
// Optional macro IF_ADDR_XLATE_EN: imem_addr_o uses the fixed kseg0/kseg1
// mapping {3'b000, pc[28:0]}; without it imem_addr_o is the virtual PC.
`ifndef EC_None
`define EC_None 5'd0
`endif
`ifndef EC_AdEL
`define EC_AdEL 5'd4
`endif

module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'hBFC0_0000,
    parameter int          BUF_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic [31:0] flush_pc_i,
    input  logic        br_i,
    input  logic [31:0] br_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    output logic [4:0]  exc_code_o,
    output logic [31:0] exc_badvaddr_o
);
    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;
    localparam cnt_t DEPTH_C = cnt_t'(BUF_DEPTH);

    logic [31:0] pc_q, pc_d;
    ptr_t        rd_ptr_q, rd_ptr_d;
    cnt_t        count_q, count_d;
    cnt_t        out_q, out_d;
    cnt_t        disc_q, disc_d;
    logic        halt_q, halt_d;
    logic        run_q;

    // Queue storage. Slots past count_q hold the PCs of in-flight requests.
    logic [BUF_DEPTH-1:0][31:0] inst_mem_q, inst_mem_d;
    logic [BUF_DEPTH-1:0][31:0] pc_mem_q, pc_mem_d;
    logic [BUF_DEPTH-1:0]       adel_mem_q, adel_mem_d;

    logic redirect, accept, resp_keep, resp_drop, adel_push, pop, push;
    cnt_t fill;
    ptr_t wr_slot, issue_slot;

    // Issue gating; run_q keeps the request low until the first edge after reset.
    always_comb begin
        redirect   = flush_i | br_i;
        fill       = count_q + out_q;
        imem_req_o = run_q && !halt_q && (pc_q[1:0] == 2'b00) && (fill < DEPTH_C) && !redirect;
        accept     = imem_req_o && imem_ready_i;
`ifdef IF_ADDR_XLATE_EN
        imem_addr_o = {3'b000, pc_q[28:0]};
`else
        imem_addr_o = pc_q;
`endif
    end

    // Next-state: redirect squashes everything, otherwise issue/response/AdEL/pop.
    always_comb begin
        pc_d       = pc_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        out_d      = out_q;
        disc_d     = disc_q;
        halt_d     = halt_q;
        inst_mem_d = inst_mem_q;
        pc_mem_d   = pc_mem_q;
        adel_mem_d = adel_mem_q;

        // A response with nothing owed (stale after reset) is ignored.
        resp_drop  = imem_rvalid_i && (disc_q != '0);
        resp_keep  = imem_rvalid_i && (disc_q == '0) && (out_q != '0);
        adel_push  = !halt_q && (pc_q[1:0] != 2'b00) && (out_q == '0) && (count_q < DEPTH_C)
                     && !redirect;
        pop        = (count_q != '0) && ready_i;
        push       = resp_keep || adel_push;
        wr_slot    = rd_ptr_q + count_q[PTR_W-1:0];
        issue_slot = wr_slot + out_q[PTR_W-1:0];

        if (redirect) begin
            pc_d    = flush_i ? flush_pc_i : br_pc_i;
            count_d = '0;
            out_d   = '0;
            halt_d  = 1'b0;
            // Everything still owed by memory must be dropped when it arrives.
            disc_d  = disc_q + out_q + cnt_t'(accept) - cnt_t'(resp_drop | resp_keep);
        end else begin
            if (accept) begin
                pc_mem_d[issue_slot] = pc_q;
                pc_d                 = pc_q + 32'd4;
            end
            if (resp_keep) begin
                inst_mem_d[wr_slot] = imem_rdata_i;
                adel_mem_d[wr_slot] = 1'b0;
            end
            if (adel_push) begin
                inst_mem_d[wr_slot] = '0;
                pc_mem_d[wr_slot]   = pc_q;
                adel_mem_d[wr_slot] = 1'b1;
                halt_d              = 1'b1;
            end
            if (pop)
                rd_ptr_d = rd_ptr_q + ptr_t'(1);
            count_d = count_q + cnt_t'(push) - cnt_t'(pop);
            out_d   = out_q + cnt_t'(accept) - cnt_t'(resp_keep);
            disc_d  = disc_q - cnt_t'(resp_drop);
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q     <= RESET_PC;
            rd_ptr_q <= '0;
            count_q  <= '0;
            out_q    <= '0;
            disc_q   <= '0;
            halt_q   <= 1'b0;
            run_q    <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            out_q    <= out_d;
            disc_q   <= disc_d;
            halt_q   <= halt_d;
            run_q    <= 1'b1;
        end
    end

    // Queue payload; contents are only observed while count_q covers them.
    always_ff @(posedge clk) begin
        inst_mem_q <= inst_mem_d;
        pc_mem_q   <= pc_mem_d;
        adel_mem_q <= adel_mem_d;
    end

    // ID outputs come straight from queue registers, zeroed when empty.
    always_comb begin
        valid_o        = (count_q != '0);
        inst_o         = '0;
        pc_o           = '0;
        exc_code_o     = `EC_None;
        exc_badvaddr_o = '0;
        if (valid_o) begin
            inst_o = inst_mem_q[rd_ptr_q];
            pc_o   = pc_mem_q[rd_ptr_q];
            if (adel_mem_q[rd_ptr_q]) begin
                exc_code_o     = `EC_AdEL;
                exc_badvaddr_o = pc_mem_q[rd_ptr_q];
            end
        end
    end
endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: memory model, stream-level reference model, directed stimulus.
module tb_if_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
    localparam int          DEPTH    = 4;
    localparam logic [4:0]  EC_NONE  = 5'd0;
    localparam logic [4:0]  EC_ADEL  = 5'd4;
`ifdef IF_ADDR_XLATE_EN
    localparam logic [31:0] LIT_FIRST_ADDR = 32'h1FC0_0000;
    localparam logic [31:0] LIT_FIRST_INST = 32'h459A_5A5A;
    localparam logic [31:0] LIT_BR_INST    = 32'h5A5A_4A5A;
`else
    localparam logic [31:0] LIT_FIRST_ADDR = 32'hBFC0_0000;
    localparam logic [31:0] LIT_FIRST_INST = 32'hE59A_5A5A;
    localparam logic [31:0] LIT_BR_INST    = 32'hDA5A_4A5A;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush_i = 1'b0, br_i = 1'b0;
    logic [31:0] flush_pc_i = '0, br_pc_i = '0;
    logic        imem_req_o, imem_ready_i = 1'b1, imem_rvalid_i = 1'b0;
    logic [31:0] imem_addr_o, imem_rdata_i = '0;
    logic        valid_o, ready_i = 1'b1;
    logic [31:0] inst_o, pc_o, exc_badvaddr_o;
    logic [4:0]  exc_code_o;

    int n_chk = 0;
    int n_err = 0;

    if_fetch_unit #(.RESET_PC(RESET_PC), .BUF_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .flush_i(flush_i), .flush_pc_i(flush_pc_i), .br_i(br_i), .br_pc_i(br_pc_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_ready_i(imem_ready_i),
        .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .valid_o(valid_o), .ready_i(ready_i), .inst_o(inst_o), .pc_o(pc_o),
        .exc_code_o(exc_code_o), .exc_badvaddr_o(exc_badvaddr_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] xl(input logic [31:0] va);
`ifdef IF_ADDR_XLATE_EN
        return {3'b000, va[28:0]};
`else
        return va;
`endif
    endfunction

    function automatic logic [31:0] memf(input logic [31:0] pa);
        return pa ^ 32'h5A5A_5A5A;
    endfunction

    // Memory: in-order, fixed latency `lat`, forgets everything on reset.
    typedef struct { int due; logic [31:0] addr; } mreq_t;
    mreq_t pend[$];
    int    lat = 1;
    initial begin
        int mcyc, last_due, d;
        mcyc = 0; last_due = 0;
        forever begin
            @(negedge clk);
            mcyc++;
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = '0;
            if (!rst) begin
                pend.delete();
                last_due = 0;
            end else if (pend.size() > 0 && pend[0].due <= mcyc) begin
                imem_rvalid_i = 1'b1;
                imem_rdata_i  = memf(pend[0].addr);
                void'(pend.pop_front());
            end
            #2;
            if (rst && imem_req_o && imem_ready_i) begin
                d = mcyc + lat;
                if (d <= last_due) d = last_due + 1;
                last_due = d;
                pend.push_back('{d, imem_addr_o});
            end
        end
    end

    // Reference model: the fetch stream is consecutive words from the last
    // redirect target, at most DEPTH fetched-but-undelivered, misaligned -> one AdEL.
    logic [31:0] exp_pc, exp_req_pc, tgt, e_inst, e_bad;
    logic [4:0]  e_exc;
    int          inflight, since, acc_total, first_valid_since;
    bit          halted, seen_first, seen_req, redir, exp_req;
    logic [31:0] first_req_addr, f_pc, f_inst, f_bad;
    logic [4:0]  f_exc;
    initial begin
        acc_total = 0; first_valid_since = -1; since = 0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                chk("rst_valid", 32'(valid_o), 32'd0);
                chk("rst_req", 32'(imem_req_o), 32'd0);
                chk("rst_inst", inst_o, 32'd0);
                chk("rst_pc", pc_o, 32'd0);
                chk("rst_exc", 32'(exc_code_o), 32'(EC_NONE));
                chk("rst_bad", exc_badvaddr_o, 32'd0);
                exp_pc = RESET_PC; exp_req_pc = RESET_PC;
                inflight = 0; halted = 0; since = 0;
                seen_first = 0; seen_req = 0; first_valid_since = -1;
            end else begin
                redir = flush_i || br_i;
                tgt   = flush_i ? flush_pc_i : br_pc_i;
                exp_req = (since > 0) && !redir && (exp_req_pc[1:0] == 2'b00) && (inflight < DEPTH);
                chk("imem_req", 32'(imem_req_o), 32'(exp_req));
                if (imem_req_o) chk("imem_addr", imem_addr_o, xl(exp_req_pc));
                if (imem_req_o && !seen_req) begin first_req_addr = imem_addr_o; seen_req = 1; end
                if (valid_o) begin
                    if (first_valid_since < 0) first_valid_since = since;
                    if (!seen_first) begin
                        f_pc = pc_o; f_inst = inst_o; f_exc = exc_code_o; f_bad = exc_badvaddr_o;
                        seen_first = 1;
                    end
                    if (halted) begin
                        chk("entry_after_adel", 32'(valid_o), 32'd0);
                    end else begin
                        if (exp_pc[1:0] != 2'b00) begin
                            e_inst = '0; e_exc = EC_ADEL; e_bad = exp_pc;
                        end else begin
                            e_inst = memf(xl(exp_pc)); e_exc = EC_NONE; e_bad = '0;
                        end
                        chk("head_pc", pc_o, exp_pc);
                        chk("head_inst", inst_o, e_inst);
                        chk("head_exc", 32'(exc_code_o), 32'(e_exc));
                        chk("head_bad", exc_badvaddr_o, e_bad);
                        if (ready_i) begin
                            if (exp_pc[1:0] != 2'b00) halted = 1;
                            else begin exp_pc = exp_pc + 32'd4; inflight--; end
                        end
                    end
                end
                if (imem_req_o && imem_ready_i) begin
                    exp_req_pc = exp_req_pc + 32'd4; inflight++; acc_total++;
                end
                if (redir) begin
                    exp_pc = tgt; exp_req_pc = tgt; inflight = 0; halted = 0; seen_first = 0;
                end
                since++;
            end
        end
    end

    task automatic redirect_pulse(input bit fl, input logic [31:0] fpc, input bit br, input logic [31:0] bpc);
        flush_i = fl; flush_pc_i = fpc; br_i = br; br_pc_i = bpc;
        @(negedge clk);
        flush_i = 1'b0; br_i = 1'b0;
    endtask

    // Directed stimulus; inputs change right after each falling edge.
    initial begin
        logic [15:0] pat_a, pat_b;
        int  a0;
        bit  found;
        pat_a = 16'b1011_0010_1110_0101;
        pat_b = 16'b0110_1101_0011_1001;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (12) @(negedge clk);
        chk("first_valid_cycle", first_valid_since, 3);
        chk("first_req_addr", first_req_addr, LIT_FIRST_ADDR);
        chk("first_pc", f_pc, RESET_PC);
        chk("first_inst", f_inst, LIT_FIRST_INST);

        // ID back-pressure bursts, queue filling and draining
        for (int i = 0; i < 16; i++) begin ready_i = pat_a[i]; @(negedge clk); end
        ready_i = 1'b1;

        // ID stalls 10 cycles right after a redirect: exactly DEPTH accepts
        a0 = acc_total;
        ready_i = 1'b0;
        redirect_pulse(1'b0, '0, 1'b1, 32'h8000_0100);
        repeat (10) @(negedge clk);
        chk("stall_accepts", acc_total - a0, DEPTH);
        chk("req_low_when_full", 32'(imem_req_o), 32'd0);
        ready_i = 1'b1;
        repeat (15) @(negedge clk);

        // latency 3, branch with requests outstanding
        lat = 3;
        repeat (15) @(negedge clk);
        redirect_pulse(1'b0, '0, 1'b1, 32'h8000_1000);
        repeat (20) @(negedge clk);
        chk("br_first_pc", f_pc, 32'h8000_1000);
        chk("br_first_inst", f_inst, LIT_BR_INST);

        // flush and branch together
        redirect_pulse(1'b1, 32'hBFC0_0380, 1'b1, 32'h8000_2000);
        repeat (15) @(negedge clk);
        chk("flush_wins_pc", f_pc, 32'hBFC0_0380);

        // misaligned branch target
        a0 = acc_total;
        redirect_pulse(1'b0, '0, 1'b1, 32'h8000_0002);
        repeat (12) @(negedge clk);
        chk("adel_exc", 32'(f_exc), 32'(EC_ADEL));
        chk("adel_bad", f_bad, 32'h8000_0002);
        chk("adel_inst", f_inst, 32'd0);
        chk("adel_no_req", acc_total - a0, 0);
        redirect_pulse(1'b0, '0, 1'b1, 32'h8000_0200);
        repeat (10) @(negedge clk);

        // memory and ID back-pressure together, latency 2
        lat = 2;
        for (int i = 0; i < 32; i++) begin
            imem_ready_i = pat_a[i % 16];
            ready_i      = pat_b[i % 16];
            @(negedge clk);
        end
        imem_ready_i = 1'b1; ready_i = 1'b1;
        repeat (10) @(negedge clk);

        // reset with two requests outstanding
        lat = 3;
        redirect_pulse(1'b0, '0, 1'b1, 32'h8000_0400);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            #3;
            if (pend.size() == 2) found = 1;
            else @(negedge clk);
        end
        chk("two_outstanding_seen", 32'(found), 32'd1);
        rst = 1'b0;
        lat = 1;
        #1;
        chk("async_rst_valid", 32'(valid_o), 32'd0);
        chk("async_rst_req", 32'(imem_req_o), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (12) @(negedge clk);
        chk("rerst_first_valid_cycle", first_valid_since, 3);
        chk("rerst_first_pc", f_pc, RESET_PC);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
